// File: rtl/dmem_axil_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_axil_master_pkg
//  Description : Shared constants for the data-side AXI4-Lite master.
//                Holds the AXI response codes, the controller state
//                encodings and a small response-classification helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_axil_master_pkg;

  // AXI4-Lite response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Controller state encodings
  localparam int         DMEM_ST_W       = 3;
  localparam logic [2:0] DMEM_ST_IDLE    = 3'd0;
  localparam logic [2:0] DMEM_ST_WR      = 3'd1;
  localparam logic [2:0] DMEM_ST_WR_RESP = 3'd2;
  localparam logic [2:0] DMEM_ST_RD_ADDR = 3'd3;
  localparam logic [2:0] DMEM_ST_RD_DATA = 3'd4;
  localparam logic [2:0] DMEM_ST_DONE    = 3'd5;

  // Anything other than OKAY is reported as an error, EXOKAY included,
  // because AXI4-Lite has no exclusive access.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != AXI_RESP_OKAY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_axil_master.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_axil_master
//  Description : Data-side AXI4-Lite master. Captures one MEM-stage load or
//                store, runs the AXI4-Lite read or write handshakes, returns
//                read data and error status, and holds the pipeline stalled
//                (mem_read_write) for the whole transaction.
//  Ports       :
//    clk, rst_n          - clock, asynchronous active-low reset
//    req_*               - MEM-stage request (valid/write/addr/wdata/wstrb)
//    mem_read_write      - stall request to the hazard unit
//    rsp_done            - one-cycle completion pulse
//    rsp_rdata, rsp_err  - last read data / last response error flag
//    m_aw*, m_w*, m_b*   - AXI4-Lite write channels
//    m_ar*, m_r*         - AXI4-Lite read channels
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_axil_master
  import dmem_axil_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // MEM-stage request
  input  logic                    req_valid,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  // Pipeline / response side
  output logic                    mem_read_write,
  output logic                    rsp_done,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  // AXI write address
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]              m_awprot,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  // AXI write data
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  // AXI write response
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  // AXI read address
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]              m_arprot,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  // AXI read data
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [DMEM_ST_W-1:0]  state;
  logic [DMEM_ST_W-1:0]  state_next;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  aw_done;
  logic                  w_done;

  logic                  accept;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  wr_both_done;

  assign accept       = (state == DMEM_ST_IDLE) && req_valid;
  assign aw_hs        = m_awvalid && m_awready;
  assign w_hs         = m_wvalid && m_wready;
  // AW and W complete independently; a handshake this cycle counts as done.
  assign wr_both_done = (aw_done || aw_hs) && (w_done || w_hs);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DMEM_ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      DMEM_ST_IDLE: begin
        if (req_valid) begin
          state_next = req_write ? DMEM_ST_WR : DMEM_ST_RD_ADDR;
        end
      end
      DMEM_ST_WR: begin
        if (wr_both_done) state_next = DMEM_ST_WR_RESP;
      end
      DMEM_ST_WR_RESP: begin
        if (m_bvalid) state_next = DMEM_ST_DONE;
      end
      DMEM_ST_RD_ADDR: begin
        if (m_arready) state_next = DMEM_ST_RD_DATA;
      end
      DMEM_ST_RD_DATA: begin
        if (m_rvalid) state_next = DMEM_ST_DONE;
      end
      // DONE never looks at req_valid, so the same instruction is not reissued.
      DMEM_ST_DONE: state_next = DMEM_ST_IDLE;
      default:      state_next = DMEM_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode: valids/readies come only from registered state and flags,
  // so there is no combinational ready-to-valid path.
  // --------------------------------------------------------------------------
  always_comb begin
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      DMEM_ST_WR: begin
        m_awvalid = !aw_done;
        m_wvalid  = !w_done;
      end
      DMEM_ST_WR_RESP: m_bready  = 1'b1;
      DMEM_ST_RD_ADDR: m_arvalid = 1'b1;
      DMEM_ST_RD_DATA: m_rready  = 1'b1;
      DMEM_ST_DONE:    rsp_done  = 1'b1;
      default: ;
    endcase
  end

  // Stall covers the request cycle and every bus-active state, and is forced
  // low while reset is asserted so the pipeline is released immediately.
  assign mem_read_write = rst_n &&
                          (accept ||
                           (state == DMEM_ST_WR)      ||
                           (state == DMEM_ST_WR_RESP) ||
                           (state == DMEM_ST_RD_ADDR) ||
                           (state == DMEM_ST_RD_DATA));

  assign m_awaddr = addr_q;
  assign m_araddr = addr_q;
  assign m_wdata  = wdata_q;
  assign m_wstrb  = wstrb_q;
  assign m_awprot = 3'b000;
  assign m_arprot = 3'b000;

  // --------------------------------------------------------------------------
  // Request capture, write-channel done flags and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (state == DMEM_ST_WR) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end

      if ((state == DMEM_ST_WR_RESP) && m_bvalid) begin
        rsp_err <= resp_is_err(m_bresp);
      end

      if ((state == DMEM_ST_RD_DATA) && m_rvalid) begin
        rsp_rdata <= m_rdata;
        rsp_err   <= resp_is_err(m_rresp);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_axil_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_axil_master
//  Description : Self-checking bench for dmem_axil_master. A delay-configurable
//                AXI4-Lite slave answers the DUT; table vectors, random
//                transactions and hand sequences are compared against a
//                transaction-level reference model.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_axil_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        mem_read_write, rsp_done, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] m_awaddr, m_wdata, m_araddr;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic        m_awready = 1'b0, m_wready = 1'b0, m_arready = 1'b0;
  logic        m_bvalid = 1'b0, m_rvalid = 1'b0;
  logic [1:0]  m_bresp = '0, m_rresp = '0;
  logic [31:0] m_rdata = '0;

  dmem_axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .mem_read_write(mem_read_write), .rsp_done(rsp_done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  // ---------------------------------------------------------------- checking
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ------------------------------------------------------------ slave model
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  s_resp  = '0;
  logic [31:0] s_rdata = '0;

  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit aw_got, w_got, b_pend, r_pend;
  bit pv_aw, pr_aw, pv_w, pr_w, pv_ar, pr_ar, pv_b, pr_b, pv_r, pr_r;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  logic [31:0] obs_awaddr, obs_wdata, obs_araddr;
  logic [3:0]  obs_wstrb;

  // Runs on the falling edge: first accounts for handshakes that completed on
  // the previous rising edge, then decides ready/valid for the next one.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      pv_aw = 0; pr_aw = 0; pv_w = 0; pr_w = 0; pv_ar = 0; pr_ar = 0;
      pv_b = 0; pr_b = 0; pv_r = 0; pr_r = 0;
    end else begin
      if (pv_aw && pr_aw) begin n_aw++; obs_awaddr = p_awaddr; aw_got = 1; aw_cnt = 0; end
      else if (pv_aw) chk("awvalid_held", {31'b0, m_awvalid}, 32'd1);
      if (pv_w && pr_w) begin n_w++; obs_wdata = p_wdata; obs_wstrb = p_wstrb; w_got = 1; w_cnt = 0; end
      else if (pv_w) chk("wvalid_held", {31'b0, m_wvalid}, 32'd1);
      if (pv_ar && pr_ar) begin n_ar++; obs_araddr = p_araddr; r_pend = 1; r_cnt = 0; ar_cnt = 0; end
      else if (pv_ar) chk("arvalid_held", {31'b0, m_arvalid}, 32'd1);
      if (pv_b && pr_b) begin n_b++; b_pend = 0; end
      if (pv_r && pr_r) begin n_r++; r_pend = 0; end
      if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
      if (m_bready) chk("bready_after_aw_w", {31'b0, b_pend}, 32'd1);

      m_awready = m_awvalid && (aw_cnt >= aw_dly);
      if (m_awvalid && !m_awready) aw_cnt++;
      m_wready = m_wvalid && (w_cnt >= w_dly);
      if (m_wvalid && !m_wready) w_cnt++;
      m_arready = m_arvalid && (ar_cnt >= ar_dly);
      if (m_arvalid && !m_arready) ar_cnt++;
      m_bvalid = b_pend && (b_cnt >= b_dly);
      m_bresp  = s_resp;
      if (b_pend && !m_bvalid) b_cnt++;
      m_rvalid = r_pend && (r_cnt >= r_dly);
      m_rdata  = m_rvalid ? s_rdata : $urandom;
      m_rresp  = m_rvalid ? s_resp : 2'b00;
      if (r_pend && !m_rvalid) r_cnt++;

      pv_aw = m_awvalid; pr_aw = m_awready; p_awaddr = m_awaddr;
      pv_w  = m_wvalid;  pr_w  = m_wready;  p_wdata = m_wdata; p_wstrb = m_wstrb;
      pv_ar = m_arvalid; pr_ar = m_arready; p_araddr = m_araddr;
      pv_b  = m_bvalid;  pr_b  = m_bready;
      pv_r  = m_rvalid;  pr_r  = m_rready;
    end
  end

  // -------------------------------------------------------- reference model
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  resp;
    logic [31:0] rdata;
    bit          hold;     // keep req_valid high while the transaction runs
    bit          keep;     // keep req_valid high into the next IDLE cycle
    int          exp_lat;  // cycles from request cycle to rsp_done
    bit          exp_err;
  } vec_t;

  logic [31:0] model_rdata = '0;

  // Request cycle, one address cycle, one response cycle, DONE, plus stalls.
  function automatic int ref_latency(input vec_t v);
    int a;
    a = (v.aw_d > v.w_d) ? v.aw_d : v.w_d;
    return v.wr ? (3 + a + v.b_d) : (3 + v.ar_d + v.r_d);
  endfunction

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle
  // after DONE.
  task automatic run_txn(input vec_t v);
    int k;
    bit done;
    int b_aw, b_w, b_b, b_ar, b_r;
    if (!req_valid) chk("idle_no_stall", {31'b0, mem_read_write}, 32'd0);
    aw_dly = v.aw_d; w_dly = v.w_d; b_dly = v.b_d; ar_dly = v.ar_d; r_dly = v.r_d;
    s_resp = v.resp; s_rdata = v.rdata;
    b_aw = n_aw; b_w = n_w; b_b = n_b; b_ar = n_ar; b_r = n_r;
    req_valid = 1; req_write = v.wr; req_addr = v.addr;
    req_wdata = v.wdata; req_wstrb = v.wstrb;
    #1;
    chk("stall_req_cycle", {31'b0, mem_read_write}, 32'd1);
    k = 0; done = 0;
    while (!done && k < 200) begin
      @(posedge clk); #1;
      k++;
      req_valid = v.hold;
      req_write = $urandom; req_addr = $urandom; req_wdata = $urandom; req_wstrb = $urandom;
      #1;
      if (rsp_done) done = 1;
      else chk("stall_busy", {31'b0, mem_read_write}, 32'd1);
    end
    chk("rsp_done_seen", {31'b0, done}, 32'd1);
    chk("latency", k, v.exp_lat);
    chk("no_stall_done", {31'b0, mem_read_write}, 32'd0);
    chk("rsp_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
    if (!v.wr) model_rdata = v.rdata;
    chk("rsp_rdata", rsp_rdata, model_rdata);
    if (!v.keep) req_valid = 0;
    @(negedge clk); #1;
    if (v.wr) begin
      chk("aw_count", n_aw - b_aw, 1);
      chk("w_count", n_w - b_w, 1);
      chk("b_count", n_b - b_b, 1);
      chk("ar_none", n_ar - b_ar, 0);
      chk("awaddr", obs_awaddr, v.addr);
      chk("wdata", obs_wdata, v.wdata);
      chk("wstrb", {28'b0, obs_wstrb}, {28'b0, v.wstrb});
    end else begin
      chk("ar_count", n_ar - b_ar, 1);
      chk("r_count", n_r - b_r, 1);
      chk("aw_none", n_aw - b_aw, 0);
      chk("araddr", obs_araddr, v.addr);
    end
    @(posedge clk); #1;
    chk("rsp_done_pulse", {31'b0, rsp_done}, 32'd0);
  endtask

  function automatic logic [31:0] bus_bits();
    return {25'b0, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_done, mem_read_write};
  endfunction

  // ---------------------------------------------------------------- stimulus
  vec_t tbl[8];
  vec_t v;

  initial begin
    //         wr addr          wdata         strb    aw w b ar r  resp   rdata         hold keep lat err
    tbl[0] = '{0, 32'h4000_0010, 32'h0,        4'h0,  0, 0, 0, 0, 0, 2'b00, 32'hDEADBEEF, 0, 0,  3, 0};
    tbl[1] = '{1, 32'h4000_0020, 32'h1234_5678, 4'h3, 3, 0, 0, 0, 0, 2'b00, 32'h0,        0, 0,  6, 0};
    tbl[2] = '{1, 32'h4000_0024, 32'hCAFE_0001, 4'hF, 0, 0, 0, 0, 0, 2'b10, 32'h0,        0, 0,  3, 1};
    tbl[3] = '{0, 32'h4000_0030, 32'h0,        4'h0,  0, 0, 0, 0, 10, 2'b00, 32'hA5A5_5A5A, 1, 0, 13, 0};
    tbl[4] = '{0, 32'h4000_0034, 32'h0,        4'h0,  0, 0, 0, 2, 1, 2'b11, 32'h0BAD_F00D, 0, 0,  6, 1};
    tbl[5] = '{1, 32'h4000_0038, 32'h5555_AAAA, 4'hC, 1, 4, 2, 0, 0, 2'b01, 32'h0,        0, 0,  9, 1};
    tbl[6] = '{0, 32'h4000_0040, 32'h0,        4'h0,  0, 0, 0, 0, 0, 2'b00, 32'h1111_1111, 1, 1,  3, 0};
    tbl[7] = '{1, 32'h4000_0044, 32'h2222_3333, 4'h1, 0, 0, 0, 0, 0, 2'b00, 32'h0,        0, 0,  3, 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bus_idle", bus_bits(), 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_err", {31'b0, rsp_err}, 32'd0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("reset_prot", {26'b0, m_awprot, m_arprot}, 32'd0);
    chk("post_reset_idle", bus_bits(), 32'd0);

    // Table vectors (directed corner cases)
    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    // Random transactions
    for (int i = 0; i < 40; i++) begin
      v.wr    = $urandom_range(0, 1);
      v.addr  = $urandom; v.wdata = $urandom; v.wstrb = $urandom;
      v.aw_d  = $urandom_range(0, 4); v.w_d  = $urandom_range(0, 4);
      v.b_d   = $urandom_range(0, 4); v.ar_d = $urandom_range(0, 4);
      v.r_d   = $urandom_range(0, 4);
      v.resp  = $urandom; v.rdata = $urandom;
      v.hold  = $urandom_range(0, 1);
      v.keep  = v.hold && ($urandom_range(0, 1) == 1);
      v.exp_lat = ref_latency(v);
      v.exp_err = (v.resp != 2'b00);
      run_txn(v);
    end

    // Asynchronous reset in the middle of a read-data wait
    begin
      int k;
      r_dly = 10; ar_dly = 0; s_resp = 2'b00; s_rdata = 32'h7777_8888;
      req_valid = 1; req_write = 0; req_addr = 32'h4000_0050;
      k = 0;
      while (!m_rready && k < 20) begin
        @(posedge clk); #1;
        k++;
      end
      chk("reached_rd_data", {31'b0, m_rready}, 32'd1);
      #2;
      rst_n = 0;
      #1;
      chk("async_reset_bus", bus_bits(), 32'd0);
      chk("async_reset_rdata", rsp_rdata, 32'd0);
      chk("async_reset_err", {31'b0, rsp_err}, 32'd0);
      model_rdata = '0;
      req_valid = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      @(posedge clk); #1;
      chk("after_reset_idle", bus_bits(), 32'd0);
      v = tbl[0];
      v.rdata = 32'h0F0F_F0F0;
      run_txn(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute backstop so the run always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
    $fatal(1);
  end

endmodule
`default_nettype wire
